// File: rtl/dpram_bw.sv
// dpram_bw -- byte-lane true dual-port synchronous RAM.
//
// Two symmetric ports (A/B) in one clock domain. Each port can read or do a
// byte-masked write every cycle. The per-port write mode decides what dout
// shows on a write cycle:
//   READ_FIRST  : the old word
//   WRITE_FIRST : the word as stored at the end of the cycle
//   NO_CHANGE   : dout holds and rvalid stays low
// If both ports write the same word in one cycle, lanes enabled on both
// ports take A's data. A read that collides with a write on the other port
// returns the old word. Out-of-range addresses (non power-of-2 depth) drop
// writes and read as zero. OUT_REG=1 adds one output register stage per
// port; rvalid travels with the data.
//
// Optional feature, macro DPRAM_CLR_EN: a clear engine zeroes the whole
// array, one word per cycle, after a clr_req pulse. While busy=1 both ports
// are ignored. Without the macro, clr_req is unused and busy is tied to 0.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   ena/enb, wea/web              port enable, write enable
//   wema/wemb [NB]                byte-lane write mask
//   addra/addrb [AW]              word address
//   dina/dinb, douta/doutb        write / read data
//   rvalida/rvalidb               dout updated this cycle
//   clr_req, busy                 clear request / clear in progress
module dpram_bw #(
    parameter int    RAM_WIDTH    = 32,
    parameter int    RAM_DEPTH    = 2048,
    parameter string WRITE_MODE_A = "READ_FIRST",
    parameter string WRITE_MODE_B = "READ_FIRST",
    parameter int    OUT_REG      = 0,
    parameter string INIT_FILE    = "NONE",
    localparam int   NB           = RAM_WIDTH / 8,
    // Bits needed to hold RAM_DEPTH-1.
    localparam int   AW           = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [NB-1:0]        wema,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 rvalida,
    input  logic                 enb,
    input  logic                 web,
    input  logic [NB-1:0]        wemb,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 rvalidb,
    input  logic                 clr_req,
    output logic                 busy
);

    localparam int MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? 1 :
                            (WRITE_MODE_A == "NO_CHANGE")   ? 2 : 0;
    localparam int MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? 1 :
                            (WRITE_MODE_B == "NO_CHANGE")   ? 2 : 0;
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(RAM_DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(RAM_DEPTH - 1);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic          busy_int;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
`ifdef DPRAM_CLR_EN
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A request in IDLE never blocks the access presented in
                // the same cycle: busy only rises after this edge.
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_int = (state_q == S_CLEAR);
    assign clr_addr = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_req;
    assign busy_int   = 1'b0;
    assign clr_we     = 1'b0;
    assign clr_addr   = '0;
`endif

    assign busy = busy_int;

    // ------------------------------------------------------------------
    // Array access: old words, lane enables and merged write words
    // ------------------------------------------------------------------
    logic                 act_a, act_b, inr_a, inr_b, same;
    logic                 wr_a, wr_b;
    logic [NB-1:0]        lane_a, lane_b;
    logic [RAM_WIDTH-1:0] old_a, old_b, fin_a, fin_b;

    always_comb begin
        act_a = ena & ~busy_int;
        act_b = enb & ~busy_int;
        inr_a = ({1'b0, addra} < DEPTH_L);
        inr_b = ({1'b0, addrb} < DEPTH_L);
        same  = (addra == addrb);
        old_a = inr_a ? mem[addra] : '0;
        old_b = inr_b ? mem[addrb] : '0;
        lane_a = {NB{act_a & wea & inr_a}} & wema;
        lane_b = {NB{act_b & web & inr_b}} & wemb;
        fin_a = old_a;
        fin_b = old_b;
        // Both ports compute the same final word on a shared address, so
        // the two array writes below never disagree; A wins shared lanes.
        for (int i = 0; i < NB; i++) begin
            if (lane_a[i])
                fin_a[i*8 +: 8] = dina[i*8 +: 8];
            else if (same && lane_b[i])
                fin_a[i*8 +: 8] = dinb[i*8 +: 8];
            if (same && lane_a[i])
                fin_b[i*8 +: 8] = dina[i*8 +: 8];
            else if (lane_b[i])
                fin_b[i*8 +: 8] = dinb[i*8 +: 8];
        end
        wr_a = |lane_a;
        wr_b = |lane_b;
    end

    // The array itself is never reset.
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_addr] <= '0;
        if (wr_a)   mem[addra]    <= fin_a;
        if (wr_b)   mem[addrb]    <= fin_b;
    end

    // ------------------------------------------------------------------
    // First output stage (write-mode selection)
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] douta_s1_q, douta_s1_d, doutb_s1_q, doutb_s1_d;
    logic                 rva_s1_q, rva_s1_d, rvb_s1_q, rvb_s1_d;

    always_comb begin
        douta_s1_d = douta_s1_q;
        rva_s1_d   = 1'b0;
        if (act_a) begin
            if (!wea || MODE_A == 0) begin
                douta_s1_d = old_a;
                rva_s1_d   = 1'b1;
            end else if (MODE_A == 1) begin
                douta_s1_d = fin_a;
                rva_s1_d   = 1'b1;
            end
        end
        doutb_s1_d = doutb_s1_q;
        rvb_s1_d   = 1'b0;
        if (act_b) begin
            if (!web || MODE_B == 0) begin
                doutb_s1_d = old_b;
                rvb_s1_d   = 1'b1;
            end else if (MODE_B == 1) begin
                doutb_s1_d = fin_b;
                rvb_s1_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta_s1_q <= '0;
            doutb_s1_q <= '0;
            rva_s1_q   <= 1'b0;
            rvb_s1_q   <= 1'b0;
        end else begin
            douta_s1_q <= douta_s1_d;
            doutb_s1_q <= doutb_s1_d;
            rva_s1_q   <= rva_s1_d;
            rvb_s1_q   <= rvb_s1_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_oreg
        logic [RAM_WIDTH-1:0] douta_s2_q, douta_s2_d, doutb_s2_q, doutb_s2_d;
        logic                 rva_s2_q, rva_s2_d, rvb_s2_q, rvb_s2_d;

        always_comb begin
            douta_s2_d = douta_s1_q;
            doutb_s2_d = doutb_s1_q;
            rva_s2_d   = rva_s1_q;
            rvb_s2_d   = rvb_s1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                douta_s2_q <= '0;
                doutb_s2_q <= '0;
                rva_s2_q   <= 1'b0;
                rvb_s2_q   <= 1'b0;
            end else begin
                douta_s2_q <= douta_s2_d;
                doutb_s2_q <= doutb_s2_d;
                rva_s2_q   <= rva_s2_d;
                rvb_s2_q   <= rvb_s2_d;
            end
        end

        assign douta   = douta_s2_q;
        assign doutb   = doutb_s2_q;
        assign rvalida = rva_s2_q;
        assign rvalidb = rvb_s2_q;
    end else begin : g_nooreg
        assign douta   = douta_s1_q;
        assign doutb   = doutb_s1_q;
        assign rvalida = rva_s1_q;
        assign rvalidb = rvb_s1_q;
    end

endmodule

// File: tb/tb_dpram_bw.sv
// Bench for dpram_bw.
//   u0: 32-bit, depth 20 (non power of 2), A READ_FIRST, B WRITE_FIRST, no out reg
//   u1: 64-bit, depth 16, A NO_CHANGE, B READ_FIRST, out reg
//   u2: 32-bit, depth 16, clear engine (only built with DPRAM_CLR_EN)
// u0/u1 are checked every cycle against word-array models.
module tb_dpram_bw;

    localparam int D0 = 20;
    localparam int D1 = 16;

    logic clk, rst_n;
    int   checks = 0;
    int   errors = 0;

    // u0
    logic        ena0, wea0, enb0, web0, clr0, busy0, rvalida0, rvalidb0;
    logic [3:0]  wema0, wemb0;
    logic [4:0]  addra0, addrb0;
    logic [31:0] dina0, dinb0, douta0, doutb0;
    // u1
    logic        ena1, wea1, enb1, web1, clr1, busy1, rvalida1, rvalidb1;
    logic [7:0]  wema1, wemb1;
    logic [3:0]  addra1, addrb1;
    logic [63:0] dina1, dinb1, douta1, doutb1;

    dpram_bw #(.RAM_WIDTH(32), .RAM_DEPTH(D0), .WRITE_MODE_A("READ_FIRST"),
               .WRITE_MODE_B("WRITE_FIRST"), .OUT_REG(0), .INIT_FILE("NONE")) u0 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena0), .wea(wea0), .wema(wema0), .addra(addra0), .dina(dina0),
        .douta(douta0), .rvalida(rvalida0),
        .enb(enb0), .web(web0), .wemb(wemb0), .addrb(addrb0), .dinb(dinb0),
        .doutb(doutb0), .rvalidb(rvalidb0),
        .clr_req(clr0), .busy(busy0));

    dpram_bw #(.RAM_WIDTH(64), .RAM_DEPTH(D1), .WRITE_MODE_A("NO_CHANGE"),
               .WRITE_MODE_B("READ_FIRST"), .OUT_REG(1), .INIT_FILE("NONE")) u1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena1), .wea(wea1), .wema(wema1), .addra(addra1), .dina(dina1),
        .douta(douta1), .rvalida(rvalida1),
        .enb(enb1), .web(web1), .wemb(wemb1), .addrb(addrb1), .dinb(dinb1),
        .doutb(doutb1), .rvalidb(rvalidb1),
        .clr_req(clr1), .busy(busy1));

`ifdef DPRAM_CLR_EN
    logic        rst2_n, ena2, wea2, enb2, web2, clr2, busy2, rvalida2, rvalidb2;
    logic [3:0]  wema2, wemb2, addra2, addrb2;
    logic [31:0] dina2, dinb2, douta2, doutb2;

    dpram_bw #(.RAM_WIDTH(32), .RAM_DEPTH(16), .WRITE_MODE_A("READ_FIRST"),
               .WRITE_MODE_B("READ_FIRST"), .OUT_REG(0), .INIT_FILE("NONE")) u2 (
        .clk(clk), .rst_n(rst2_n),
        .ena(ena2), .wea(wea2), .wema(wema2), .addra(addra2), .dina(dina2),
        .douta(douta2), .rvalida(rvalida2),
        .enb(enb2), .web(web2), .wemb(wemb2), .addrb(addrb2), .dinb(dinb2),
        .doutb(doutb2), .rvalidb(rvalidb2),
        .clr_req(clr2), .busy(busy2));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference models: plain word arrays plus expected outputs.
    logic [31:0] m0 [D0];
    logic [63:0] m1 [D1];
    logic [31:0] e0da, e0db;
    logic        e0ra, e0rb;
    logic [63:0] s1da, s1db;   // u1 words read this cycle (visible one cycle later)
    logic        s1ra, s1rb;
    logic [63:0] o1da, o1db;
    logic        o1ra, o1rb;

    function automatic logic [31:0] rd0(input logic [4:0] a);
        return (int'(a) < D0) ? m0[a] : 32'h0;
    endfunction

    function automatic logic [63:0] p1(input int i);
        return {32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 7)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ena0 = 0; wea0 = 0; enb0 = 0; web0 = 0;
        ena1 = 0; wea1 = 0; enb1 = 0; web1 = 0;
    endtask

    // One clock: update models from the inputs now applied, then compare.
    task automatic tick();
        logic [31:0] oa0, ob0;
        logic [63:0] oa1, ob1;
        oa0 = rd0(addra0);
        ob0 = rd0(addrb0);
        if (enb0 && web0 && int'(addrb0) < D0)
            for (int i = 0; i < 4; i++) if (wemb0[i]) m0[addrb0][8*i +: 8] = dinb0[8*i +: 8];
        if (ena0 && wea0 && int'(addra0) < D0)
            for (int i = 0; i < 4; i++) if (wema0[i]) m0[addra0][8*i +: 8] = dina0[8*i +: 8];
        e0ra = ena0;
        if (ena0) e0da = oa0;
        e0rb = enb0;
        if (enb0) e0db = web0 ? rd0(addrb0) : ob0;

        o1da = s1da; o1ra = s1ra; o1db = s1db; o1rb = s1rb;
        oa1 = m1[addra1];
        ob1 = m1[addrb1];
        if (enb1 && web1)
            for (int i = 0; i < 8; i++) if (wemb1[i]) m1[addrb1][8*i +: 8] = dinb1[8*i +: 8];
        if (ena1 && wea1)
            for (int i = 0; i < 8; i++) if (wema1[i]) m1[addra1][8*i +: 8] = dina1[8*i +: 8];
        s1ra = ena1 && !wea1;
        if (s1ra) s1da = oa1;
        s1rb = enb1;
        if (enb1) s1db = ob1;

        @(posedge clk);
        #1;
        chk("u0_douta", douta0, e0da);   chk("u0_rvalida", rvalida0, e0ra);
        chk("u0_doutb", doutb0, e0db);   chk("u0_rvalidb", rvalidb0, e0rb);
        chk("u1_douta", douta1, o1da);   chk("u1_rvalida", rvalida1, o1ra);
        chk("u1_doutb", doutb1, o1db);   chk("u1_rvalidb", rvalidb1, o1rb);
        chk("u0_busy", busy0, 0);        chk("u1_busy", busy1, 0);
    endtask

`ifdef DPRAM_CLR_EN
    // Pulse clr_req on u2, count busy cycles while hammering port A.
    task automatic clear_run(output int nbusy);
        ena2 = 0; clr2 = 1; tick(); clr2 = 0;
        nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy2) break;
            nbusy++;
            ena2 = 1; wea2 = 1; wema2 = 4'hF; addra2 = 4'(c); dina2 = 32'h5555_5555;
            clr2 = (c == 3);   // must be ignored while busy
            tick();
            chk("clr_rvalida_busy", rvalida2, 0);
        end
        ena2 = 0; clr2 = 0;
    endtask
`endif

    initial begin
        int nb;
        logic [63:0] hold;
        rst_n = 1; clr0 = 0; clr1 = 0;
        idle();
        wema0 = 0; wemb0 = 0; addra0 = 0; addrb0 = 0; dina0 = 0; dinb0 = 0;
        wema1 = 0; wemb1 = 0; addra1 = 0; addrb1 = 0; dina1 = 0; dinb1 = 0;
        e0da = 0; e0db = 0; e0ra = 0; e0rb = 0;
        s1da = 0; s1db = 0; s1ra = 0; s1rb = 0;
`ifdef DPRAM_CLR_EN
        rst2_n = 1; ena2 = 0; wea2 = 0; enb2 = 0; web2 = 0; clr2 = 0;
        wema2 = 0; wemb2 = 0; addra2 = 0; addrb2 = 0; dina2 = 0; dinb2 = 0;
`endif
        #2 rst_n = 0;
`ifdef DPRAM_CLR_EN
        rst2_n = 0;
`endif
        #1;
        chk("rst_douta0", douta0, 0);  chk("rst_rvalida0", rvalida0, 0);
        chk("rst_doutb0", doutb0, 0);  chk("rst_rvalidb0", rvalidb0, 0);
        chk("rst_douta1", douta1, 0);  chk("rst_rvalidb1", rvalidb1, 0);
        chk("rst_busy0", busy0, 0);
        @(negedge clk);
        rst_n = 1;
`ifdef DPRAM_CLR_EN
        rst2_n = 1;
        chk("rst_busy2", busy2, 0);
`endif

        // Fill both arrays with known contents.
        for (int i = 0; i < D0; i++) begin
            idle(); ena0 = 1; wea0 = 1; wema0 = 4'hF; addra0 = 5'(i); dina0 = 32'hC0DE_0000 + 32'(i);
            if (i < D1) begin ena1 = 1; wea1 = 1; wema1 = 8'hFF; addra1 = 4'(i); dina1 = p1(i); end
            tick();
        end
        idle(); tick();

        // Continuous reads on u1 port B: two-cycle latency, no bubbles.
        for (int k = 0; k < 18; k++) begin
            enb1 = (k < 16); addrb1 = 4'(k);
            tick();
            if (k >= 1 && k <= 16) begin
                chk("stream_rvalidb", rvalidb1, 1);
                chk("stream_doutb", doutb1, p1(k - 1));
            end
        end
        idle();

        // Full-word write on A, one-lane write on B, read back on A.
        ena0 = 1; wea0 = 1; wema0 = 4'hF; addra0 = 5; dina0 = 32'hDEAD_BEEF; tick(); idle();
        enb0 = 1; web0 = 1; wemb0 = 4'b0001; addrb0 = 5; dinb0 = 32'h0000_00AA; tick(); idle();
        ena0 = 1; addra0 = 5; tick(); idle();
        chk("tp_merge_douta", douta0, 32'hDEAD_BEAA);
        chk("tp_merge_rvalida", rvalida0, 1);

        // Write modes: READ_FIRST on A, WRITE_FIRST on B.
        ena0 = 1; wea0 = 1; wema0 = 4'hF; addra0 = 3; dina0 = 32'h1111_1111; tick();
        dina0 = 32'h2222_2222; tick(); idle();
        chk("rf_douta", douta0, 32'h1111_1111);
        enb0 = 1; web0 = 1; wemb0 = 4'hF; addrb0 = 3; dinb0 = 32'h3333_3333; tick(); idle();
        chk("wf_doutb", doutb0, 32'h3333_3333);

        // NO_CHANGE on u1 A: a read, then a write; dout holds, rvalid low.
        ena1 = 1; addra1 = 3; tick();
        wea1 = 1; wema1 = 8'hFF; dina1 = 64'h0123_4567_89AB_CDEF; tick(); idle();
        chk("nc_read_douta1", douta1, p1(3));
        chk("nc_read_rvalida1", rvalida1, 1);
        tick();
        chk("nc_hold_douta1", douta1, p1(3));
        chk("nc_rvalida1", rvalida1, 0);

        // Same-address collisions at 7.
        ena0 = 1; wea0 = 1; wema0 = 4'hF; addra0 = 7; dina0 = 32'h1234_5678; tick(); idle();
        ena0 = 1; wea0 = 1; wema0 = 4'b0011; addra0 = 7; dina0 = 32'hAAAA_AAAA;
        enb0 = 1; web0 = 1; wemb0 = 4'b0110; addrb0 = 7; dinb0 = 32'hBBBB_BBBB; tick(); idle();
        ena0 = 1; addra0 = 7;
        enb0 = 1; web0 = 1; wemb0 = 4'hF; addrb0 = 7; dinb0 = 32'h5555_5555; tick(); idle();
        chk("ww_then_rw_old", douta0, 32'h12BB_AAAA);
        ena0 = 1; addra0 = 7; tick(); idle();
        chk("rw_write_done", douta0, 32'h5555_5555);

        // Out-of-range addresses: writes dropped, reads zero.
        ena0 = 1; wea0 = 1; wema0 = 4'hF; addra0 = 25; dina0 = 32'hFFFF_FFFF; tick(); idle();
        ena0 = 1; addra0 = 25; enb0 = 1; addrb0 = 20; tick(); idle();
        chk("oob_douta", douta0, 0);
        chk("oob_doutb", doutb0, 0);
        chk("oob_rvalida", rvalida0, 1);

        // Randomized traffic on both instances, collisions encouraged.
        for (int n = 0; n < 400; n++) begin
            ena0 = ($urandom_range(0, 3) != 0); wea0 = $urandom_range(0, 1);
            wema0 = 4'($urandom); addra0 = 5'($urandom_range(0, 21)); dina0 = $urandom;
            enb0 = ($urandom_range(0, 3) != 0); web0 = $urandom_range(0, 1);
            wemb0 = 4'($urandom); dinb0 = $urandom;
            addrb0 = ($urandom_range(0, 3) == 0) ? addra0 : 5'($urandom_range(0, 21));
            ena1 = ($urandom_range(0, 3) != 0); wea1 = $urandom_range(0, 1);
            wema1 = 8'($urandom); addra1 = 4'($urandom); dina1 = {$urandom, $urandom};
            enb1 = ($urandom_range(0, 3) != 0); web1 = $urandom_range(0, 1);
            wemb1 = 8'($urandom); dinb1 = {$urandom, $urandom};
            addrb1 = ($urandom_range(0, 3) == 0) ? addra1 : 4'($urandom);
            tick();
        end
        idle(); tick(); tick();

`ifdef DPRAM_CLR_EN
        // Full clear of u2.
        for (int i = 0; i < 16; i++) begin
            ena2 = 1; wea2 = 1; wema2 = 4'hF; addra2 = 4'(i); dina2 = 32'hFFFF_FFFF; tick();
        end
        clear_run(nb);
        chk("clr_busy_cycles", nb, 16);
        for (int i = 0; i < 16; i++) begin
            ena2 = 1; wea2 = 0; addra2 = 4'(i); tick();
            chk("clr_word_zero", douta2, 0);
            chk("clr_word_rvalid", rvalida2, 1);
        end
        // Reset in the middle of a clear.
        for (int i = 0; i < 16; i++) begin
            ena2 = 1; wea2 = 1; wema2 = 4'hF; addra2 = 4'(i); dina2 = 32'hFFFF_FFFF; tick();
        end
        ena2 = 0; clr2 = 1; tick(); clr2 = 0;
        for (int c = 0; c < 5; c++) tick();
        chk("clr6_busy_before", busy2, 1);
        #2 rst2_n = 0;
        #1 chk("clr6_busy_async", busy2, 0);
        #1 rst2_n = 1;
        ena2 = 1; wea2 = 0; addra2 = 0; tick();
        chk("partial_low_cleared", douta2, 0);
        addra2 = 15; tick();
        chk("partial_high_kept", douta2, 32'hFFFF_FFFF);
        clear_run(nb);
        chk("reclr_busy_cycles", nb, 16);
        for (int i = 0; i < 16; i++) begin
            ena2 = 1; wea2 = 0; addra2 = 4'(i); tick();
            chk("reclr_word_zero", douta2, 0);
        end
        ena2 = 0; tick();
`endif

        hold = 64'(errors);
        $display("Result: errors=%0d of %0d checks", hold, checks);
        $finish;
    end

endmodule
